booth_mult_pipe: RTL and testbench

//  Streaming W x W multiplier: radix-4 Booth partial-product generation, Wallace-style compressor

---
 rtl/booth_mult_pipe.sv | 244 ++++++++++++++++++++++++
 tb/tb_booth_mult_pipe.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_pipe.sv
// Streaming W x W radix-4 Booth multiplier with a carry-save compressor tree and a
// hole-filling valid/ready pipeline. Optional counters under BOOTH_MULT_PERF_EN.
module booth_mult_pipe #(
    parameter int W           = 16,
    parameter int PIPE_STAGES = 3,
    parameter int TAG_W       = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       in_a,
    input  logic [W-1:0]       in_b,
    input  logic               in_signed,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*W-1:0]     out_prod,
    output logic [TAG_W-1:0]   out_tag
`ifdef BOOTH_MULT_PERF_EN
    ,
    output logic [31:0]        perf_ops,
    output logic [31:0]        perf_stall
`endif
);

    localparam int WE     = W + (W % 2);
    localparam int NUM_PP = WE / 2 + 1;
    localparam int NR     = NUM_PP + 1;
    localparam int NRP    = NR + 2;
    localparam int PW     = 2 * W;
    localparam int BXW    = WE + 3;
    localparam int NPAIR  = (PIPE_STAGES > 1) ? PIPE_STAGES - 1 : 1;

    logic [PW-1:0]  a_full;
    logic [BXW-1:0] bx;
    logic [PW-1:0]  rows [NUM_PP];
    logic           neg_dig [NUM_PP];
    logic [PW-1:0]  neg_bits;
    logic [PW-1:0]  tree_sum;
    logic [PW-1:0]  tree_carry;

    // Operands extended per op; all arithmetic is modulo 2^(2W).
    assign a_full = {{W{in_signed & in_a[W-1]}}, in_a};
    assign bx     = {{(BXW-W-1){in_signed & in_b[W-1]}}, in_b, 1'b0};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PP; gi++) begin : g_booth
            logic [2:0]    dig;
            logic          live;
            logic          one;
            logic          two;
            logic          neg;
            logic [PW-1:0] mag;

            assign dig  = bx[2*gi+2 -: 3];
            // Top row only carries the unsigned top digit.
            assign live = (gi == NUM_PP - 1) ? ~in_signed : 1'b1;
            assign one  = live & (dig[1] ^ dig[0]);
            assign two  = live & ((dig[2] & ~dig[1] & ~dig[0]) | (~dig[2] & dig[1] & dig[0]));
            assign neg  = live & dig[2] & ~(dig[1] & dig[0]);
            assign mag  = one ? a_full : (two ? {a_full[PW-2:0], 1'b0} : '0);
            assign rows[gi]    = (neg ? ~mag : mag) << (2 * gi);
            assign neg_dig[gi] = neg;
        end
    endgenerate

    // Two's-complement +1 of each negated row enters the tree as its own input row.
    always_comb begin
        neg_bits = '0;
        for (int i = 0; i < NUM_PP; i++) begin
            neg_bits[2*i] = neg_dig[i];
        end
    end

    // Wallace reduction: each level compresses every full triple of rows with 3:2 counters.
    always_comb begin
        logic [PW-1:0] cur [NRP];
        logic [PW-1:0] nxt [NRP];
        int            cnt;
        int            n;
        for (int i = 0; i < NRP; i++) begin
            cur[i] = '0;
            nxt[i] = '0;
        end
        for (int i = 0; i < NUM_PP; i++) begin
            cur[i] = rows[i];
        end
        cur[NUM_PP] = neg_bits;
        cnt = NR;
        n   = 0;
        for (int lv = 0; lv < NR; lv++) begin
            if (cnt > 2) begin
                for (int i = 0; i < NRP; i++) begin
                    nxt[i] = '0;
                end
                n = 0;
                for (int j = 0; j < NR; j += 3) begin
                    if (j + 2 < cnt) begin
                        nxt[n]   = cur[j] ^ cur[j+1] ^ cur[j+2];
                        nxt[n+1] = ((cur[j] & cur[j+1]) | (cur[j] & cur[j+2]) |
                                    (cur[j+1] & cur[j+2])) << 1;
                        n = n + 2;
                    end else if (j < cnt) begin
                        nxt[n] = cur[j];
                        n = n + 1;
                        if (j + 1 < cnt) begin
                            nxt[n] = cur[j+1];
                            n = n + 1;
                        end
                    end
                end
                for (int i = 0; i < NRP; i++) begin
                    cur[i] = nxt[i];
                end
                cnt = n;
            end
        end
        tree_sum   = cur[0];
        tree_carry = cur[1];
    end

    logic [PIPE_STAGES-1:0] vld_reg;
    logic [PIPE_STAGES-1:0] adv;
    logic [PIPE_STAGES-1:0] load;
    logic [PIPE_STAGES-1:0] src_vld;
    logic                   accept;
    logic [TAG_W-1:0]       tag_reg   [PIPE_STAGES];
    logic [TAG_W-1:0]       src_tag   [PIPE_STAGES];
    logic [PW-1:0]          sum_reg   [NPAIR];
    logic [PW-1:0]          carry_reg [NPAIR];
    logic [PW-1:0]          src_sum   [NPAIR];
    logic [PW-1:0]          src_carry [NPAIR];
    logic [PW-1:0]          fin_sum;
    logic [PW-1:0]          fin_carry;
    logic [PW-1:0]          prod_reg;

    // Stage k may load when empty or when its content moves on; resolved from the output back.
    always_comb begin
        logic go;
        adv  = '0;
        load = '0;
        go   = out_ready;
        for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
            adv[k]  = go;
            load[k] = ~vld_reg[k] | go;
            go      = load[k];
        end
    end

    assign in_ready = rst & ~flush & load[0];
    assign accept   = in_valid & in_ready;

    always_comb begin
        src_vld    = {vld_reg[PIPE_STAGES-2:0], accept} ;
        src_tag[0] = in_tag;
        for (int k = 1; k < PIPE_STAGES; k++) begin
            src_tag[k] = tag_reg[k-1];
        end
        src_sum[0]   = tree_sum;
        src_carry[0] = tree_carry;
        for (int k = 1; k < NPAIR; k++) begin
            src_sum[k]   = sum_reg[k-1];
            src_carry[k] = carry_reg[k-1];
        end
    end

    generate
        if (PIPE_STAGES == 1) begin : g_fin_direct
            assign fin_sum   = tree_sum;
            assign fin_carry = tree_carry;
        end else begin : g_fin_piped
            assign fin_sum   = sum_reg[NPAIR-1];
            assign fin_carry = carry_reg[NPAIR-1];
        end
    endgenerate

    // Data only moves with a valid op and never during flush, so outputs hold their last value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_reg  <= '0;
            prod_reg <= '0;
            for (int k = 0; k < PIPE_STAGES; k++) begin
                tag_reg[k] <= '0;
            end
            for (int k = 0; k < NPAIR; k++) begin
                sum_reg[k]   <= '0;
                carry_reg[k] <= '0;
            end
        end else begin
            for (int k = 0; k < PIPE_STAGES; k++) begin
                if (flush) begin
                    vld_reg[k] <= 1'b0;
                end else if (load[k]) begin
                    vld_reg[k] <= src_vld[k];
                end
                if (!flush && load[k] && src_vld[k]) begin
                    tag_reg[k] <= src_tag[k];
                end
            end
            for (int k = 0; k < NPAIR; k++) begin
                if (PIPE_STAGES > 1 && !flush && load[k] && src_vld[k]) begin
                    sum_reg[k]   <= src_sum[k];
                    carry_reg[k] <= src_carry[k];
                end
            end
            if (!flush && load[PIPE_STAGES-1] && src_vld[PIPE_STAGES-1]) begin
                prod_reg <= fin_sum + fin_carry;
            end
        end
    end

    assign out_valid = vld_reg[PIPE_STAGES-1];
    assign out_prod  = prod_reg;
    assign out_tag   = tag_reg[PIPE_STAGES-1];

`ifdef BOOTH_MULT_PERF_EN
    logic [31:0] perf_ops_reg;
    logic [31:0] perf_stall_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_ops_reg   <= '0;
            perf_stall_reg <= '0;
        end else if (flush) begin
            perf_ops_reg   <= '0;
            perf_stall_reg <= '0;
        end else begin
            if (accept) begin
                perf_ops_reg <= perf_ops_reg + 32'd1;
            end
            if (out_valid && !out_ready) begin
                perf_stall_reg <= perf_stall_reg + 32'd1;
            end
        end
    end

    assign perf_ops   = perf_ops_reg;
    assign perf_stall = perf_stall_reg;
`endif

endmodule

// File: tb/tb_booth_mult_pipe.sv
// Directed bench for booth_mult_pipe at W=8, PIPE_STAGES=3, TAG_W=4.
// Perf counter checks are compiled in when BOOTH_MULT_PERF_EN is defined.
module tb_booth_mult_pipe;
    localparam int W  = 8;
    localparam int P  = 3;
    localparam int TW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_a;
    logic [W-1:0]    in_b;
    logic            in_signed;
    logic [TW-1:0]   in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [2*W-1:0]  out_prod;
    logic [TW-1:0]   out_tag;
`ifdef BOOTH_MULT_PERF_EN
    logic [31:0]     perf_ops;
    logic [31:0]     perf_stall;
`endif

    int checks = 0;
    int errors = 0;

    // Hand-computed vectors for streaming tests.
    logic [7:0]  va [8] = '{8'h03, 8'hFE, 8'h10, 8'h80, 8'hFF, 8'hFF, 8'h12, 8'h81};
    logic [7:0]  vb [8] = '{8'h05, 8'h03, 8'h10, 8'h7F, 8'h02, 8'hFF, 8'h34, 8'h81};
    logic        vs [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] vp [8] = '{16'h000F, 16'hFFFA, 16'h0100, 16'hC080,
                            16'h01FE, 16'h0001, 16'h03A8, 16'h3F01};

    always #5 clk = ~clk;

    booth_mult_pipe #(.W(W), .PIPE_STAGES(P), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_signed (in_signed),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .out_tag   (out_tag)
`ifdef BOOTH_MULT_PERF_EN
        ,
        .perf_ops  (perf_ops),
        .perf_stall(perf_stall)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One op into an empty pipe; checks latency, product and tag, then drains it.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                          input logic [3:0] t, input logic [15:0] exp, input string name);
        int lat;
        in_a = a; in_b = b; in_signed = s; in_tag = t; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check({name, "_rdy"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_lat"}, lat, 3);
        check({name, "_prod"}, out_prod, exp);
        check({name, "_tag"}, out_tag, t);
        $display("op %s a=%h b=%h s=%0d tag=%h prod=%h lat=%0d", name, a, b, s, out_tag, out_prod, lat);
        @(posedge clk); #1;
    endtask

    // Streams n ops from the vector table with out_ready low for cycles lo..hi.
    task automatic stream(input int n, input int lo, input int hi);
        int sent = 0;
        int rcv = 0;
        int viol = 0;
        int full_seen = 0;
        logic do_in, do_out;
        for (int c = 0; c < 80 && rcv < n; c++) begin
            out_ready = !(c >= lo && c <= hi);
            in_valid  = (sent < n);
            in_a      = va[sent % 8];
            in_b      = vb[sent % 8];
            in_signed = vs[sent % 8];
            in_tag    = sent[3:0];
            #1;
            if (sent - rcv == 3 && !out_ready) begin
                full_seen = 1;
                if (in_ready) viol++;
            end
            do_in  = in_valid && in_ready;
            do_out = out_valid && out_ready;
            if (do_out) begin
                check("strm_prod", out_prod, vp[rcv % 8]);
                check("strm_tag", out_tag, rcv[3:0]);
                $display("strm out tag=%h prod=%h cycle=%0d", out_tag, out_prod, c);
                rcv++;
            end
            if (do_in) sent++;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("strm_count", rcv, n);
        check("strm_full_seen", full_seen, 1);
        check("strm_full_ready", viol, 0);
    endtask

    initial begin
        int acc;
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_signed = 1'b0; in_tag = '0; out_ready = 1'b1;

        @(posedge clk); #1;
        check("rst_vld", out_valid, 0);
        check("rst_prod", out_prod, 0);
        check("rst_tag", out_tag, 0);
        check("rst_rdy", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rel_rdy", in_ready, 1);

        run_op(8'h80, 8'h80, 1'b1, 4'h5, 16'h4000, "s80x80");
        run_op(8'hFF, 8'hFF, 1'b0, 4'h1, 16'hFE01, "uFFxFF");
        run_op(8'hFF, 8'hFF, 1'b1, 4'h2, 16'h0001, "sFFxFF");
        run_op(8'hFF, 8'h01, 1'b1, 4'h3, 16'hFFFF, "sFFx01");
        run_op(8'hFF, 8'h01, 1'b0, 4'h4, 16'h00FF, "uFFx01");
        run_op(8'h7F, 8'h80, 1'b1, 4'h6, 16'hC080, "s7Fx80");
        run_op(8'hAB, 8'hCD, 1'b0, 4'h7, 16'h88EF, "uABxCD");

        stream(8, 2, 6);

        // Flush with three ops held and a new op offered.
        out_ready = 1'b0; in_valid = 1'b1; in_a = 8'h01; in_b = 8'h01;
        in_signed = 1'b0; in_tag = 4'h9;
        acc = 0;
        for (int c = 0; c < 10 && acc < 3; c++) begin
            #1;
            if (in_ready) acc++;
            @(posedge clk); #1;
        end
        check("fl_fill", acc, 3);
        check("fl_pre_vld", out_valid, 1);
        flush = 1'b1;
        #1;
        check("fl_rdy", in_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        check("fl_vld", out_valid, 0);
        @(posedge clk); #1;
        check("fl_vld2", out_valid, 0);
        run_op(8'h02, 8'h03, 1'b0, 4'h3, 16'h0006, "fl_new");

        // Asynchronous reset while the pipe is full and an output is presented.
        in_valid = 1'b1; in_a = 8'h03; in_b = 8'h05; in_signed = 1'b0; in_tag = 4'hA;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
        end
        check("rs_pre_vld", out_valid, 1);
        check("rs_pre_prod", out_prod, 16'h000F);
        rst = 1'b0;
        #1;
        check("rs_vld", out_valid, 0);
        check("rs_prod", out_prod, 0);
        check("rs_tag", out_tag, 0);
        check("rs_rdy", in_ready, 0);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rs_rel_rdy", in_ready, 1);
        check("rs_rel_vld", out_valid, 0);
        run_op(8'hFF, 8'h01, 1'b1, 4'hB, 16'hFFFF, "rs_new");

`ifdef BOOTH_MULT_PERF_EN
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("perf_clr_ops", perf_ops, 0);
        check("perf_clr_stall", perf_stall, 0);
        stream(10, 2, 6);
        check("perf_ops", perf_ops, 10);
        check("perf_stall", perf_stall, 4);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("perf_fl_ops", perf_ops, 0);
        check("perf_fl_stall", perf_stall, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
